// File: rtl/lab01_sweep_ctrl_pkg.sv
// Shared types and defaults for the lab01 exhaustive sweep sequencer.
package lab01_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int          LAB01_N_IN   = 4;
  localparam int          LAB01_N_DUT  = 3;
  // Bit i is Y = NOR(A,B) & NAND(C,D) for vector i = {A,B,C,D}.
  localparam logic [15:0] LAB01_GOLDEN = 16'h0007;

endpackage

// File: rtl/lab01_sweep_ctrl_if.sv
// Sequencer-facing bundle: sweep control, the shared input bus and the result registers.
interface lab01_sweep_ctrl_if
  import lab01_sweep_ctrl_pkg::*;
#(
  parameter int N_IN  = LAB01_N_IN,
  parameter int N_DUT = LAB01_N_DUT
) ();

  localparam int NV = 2 ** N_IN;
  localparam int CW = $clog2(NV + 1);

  // Control is level based, not a valid/ready pair: start is taken only while
  // the controller is idle (busy low), abort only while busy; done and aborted
  // are single-cycle completion pulses and the results hold until the next start.
  logic             start;
  logic             abort;
  logic [N_DUT-1:0] y_in;
  logic [N_IN-1:0]  drive;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NV-1:0]    tt;
  logic [NV-1:0]    mismatch_mask;
  logic [CW-1:0]    err_count;
  logic             first_err_valid;
  logic [N_IN-1:0]  first_err_idx;

  modport master (
    output start, abort, y_in,
    input  drive, busy, done, aborted, tt, mismatch_mask,
           err_count, first_err_valid, first_err_idx
  );

  modport slave (
    input  start, abort, y_in,
    output drive, busy, done, aborted, tt, mismatch_mask,
           err_count, first_err_valid, first_err_idx
  );

endinterface

// File: rtl/lab01_sweep_ctrl_vec_checker.sv
// Flags a vector when any implementation output disagrees with the golden bit.
module lab01_sweep_ctrl_vec_checker
  import lab01_sweep_ctrl_pkg::*;
#(
  parameter int N_DUT = LAB01_N_DUT
) (
  input  logic [N_DUT-1:0] y_in,
  input  logic             golden,
  output logic             mismatch
);

  assign mismatch = |(y_in ^ {N_DUT{golden}});

endmodule

// File: rtl/lab01_sweep_ctrl.sv
// Steps {A,B,C,D} through 0..2**N_IN-1, samples every implementation output on the
// last settle cycle of each vector and accumulates truth table and mismatch results.
module lab01_sweep_ctrl
  import lab01_sweep_ctrl_pkg::*;
#(
  parameter int                   N_IN          = LAB01_N_IN,
  parameter int                   N_DUT         = LAB01_N_DUT,
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0]   GOLDEN        = LAB01_GOLDEN
) (
  input  logic               clk,
  input  logic               rst,
  lab01_sweep_ctrl_if.slave  bus,
  output state_t             dbg_state
);

  localparam int NV = 2 ** N_IN;
  localparam int CW = $clog2(NV + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q;
  logic [SW-1:0]   cnt_q;
  logic [NV-1:0]   tt_q;
  logic [NV-1:0]   mask_q;
  logic [CW-1:0]   err_q;
  logic            fev_q;
  logic [N_IN-1:0] fei_q;
  logic            aborted_q;

  logic clear_res;
  logic sample;
  logic abort_hit;
  logic last_cnt;
  logic vec_mismatch;

  assign last_cnt = (cnt_q == SW'(SETTLE_CYCLES - 1));

  lab01_sweep_ctrl_vec_checker #(.N_DUT(N_DUT)) u_checker (
    .y_in     (bus.y_in),
    .golden   (GOLDEN[idx_q]),
    .mismatch (vec_mismatch)
  );

  always_comb begin
    state_d   = state_q;
    clear_res = 1'b0;
    sample    = 1'b0;
    abort_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          clear_res = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks the sampling edge, so an aborted vector is never recorded.
        if (bus.abort) begin
          abort_hit = 1'b1;
          state_d   = ST_IDLE;
        end else if (last_cnt) begin
          sample = 1'b1;
          if (idx_q == N_IN'(NV - 1)) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tt_q      <= '0;
      mask_q    <= '0;
      err_q     <= '0;
      fev_q     <= 1'b0;
      fei_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aborted_q <= abort_hit;
      if (clear_res) begin
        idx_q  <= '0;
        cnt_q  <= '0;
        tt_q   <= '0;
        mask_q <= '0;
        err_q  <= '0;
        fev_q  <= 1'b0;
        fei_q  <= '0;
      end else if (state_q == ST_RUN && !abort_hit) begin
        if (sample) begin
          tt_q[idx_q]   <= bus.y_in[0];
          mask_q[idx_q] <= vec_mismatch;
          if (vec_mismatch) begin
            err_q <= err_q + CW'(1);
            if (!fev_q) begin
              fev_q <= 1'b1;
              fei_q <= idx_q;
            end
          end
          idx_q <= idx_q + N_IN'(1);
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + SW'(1);
        end
      end
    end
  end

  assign bus.drive           = (state_q == ST_RUN) ? idx_q : '0;
  assign bus.busy            = (state_q == ST_RUN);
  assign bus.done            = (state_q == ST_FIN);
  assign bus.aborted         = aborted_q;
  assign bus.tt              = tt_q;
  assign bus.mismatch_mask   = mask_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;
  assign dbg_state           = state_q;

endmodule
